// File: rtl/aer_to_parallel.sv
// AER event receiver: collects per-timestep spike bitmaps from a 4-phase REQ/ACK link
// and drains them, MSB-first, as DATA_WIDTH-bit words on a valid/ready stream.
module aer_to_parallel #(
    parameter int unsigned DATA_WIDTH = 4,
    parameter int unsigned NEURON_NUM = 784,
    parameter int unsigned T_STEPS    = 16
) (
    input  logic                  CLK,
    input  logic                  rst_n,
    input  logic                  AER_OUT_REQ,
    input  logic [11:0]           AER_OUT_ADDR,
    output logic                  AER_OUT_ACK,
    output logic [DATA_WIDTH-1:0] dout_parallel,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic                  dout_last,
    output logic [3:0]            tstep_cnt,
    output logic                  finish,
    output logic                  addr_err
);

    localparam int unsigned    WORDS      = NEURON_NUM / DATA_WIDTH;
    localparam int unsigned    WCW        = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [WCW-1:0] LAST_WORD  = WCW'(WORDS - 1);
    localparam logic [10:0]    NEURON_LIM = 11'(NEURON_NUM);
    localparam logic [3:0]     LAST_STEP  = 4'(T_STEPS - 1);

    typedef enum logic [1:0] {Collect, HoldAck, Drain} state_e;

    state_e                state;
    logic [NEURON_NUM-1:0] bitmap;
    logic [WCW-1:0]        word_cnt;
    logic                  is_marker;
    logic                  spike_ok;
    logic                  last_word;
    logic [9:0]            base;

    assign is_marker = AER_OUT_ADDR[11:10] == 2'b01;
    assign spike_ok  = !AER_OUT_ADDR[11] && ({1'b0, AER_OUT_ADDR[9:0]} < NEURON_LIM);
    assign last_word = word_cnt == LAST_WORD;
    assign dout_last = dout_valid && last_word;
    assign base      = 10'(word_cnt) * 10'(DATA_WIDTH);

    // Lowest-numbered neuron of the word lands in the MSB.
    always_comb begin
        dout_parallel = '0;
        for (int j = 0; j < DATA_WIDTH; j++) begin
            dout_parallel[DATA_WIDTH-1-j] = bitmap[base + 10'(j)];
        end
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state       <= Collect;
            bitmap      <= '0;
            word_cnt    <= '0;
            tstep_cnt   <= '0;
            AER_OUT_ACK <= 1'b0;
            dout_valid  <= 1'b0;
            finish      <= 1'b0;
            addr_err    <= 1'b0;
        end else begin
            finish <= 1'b0;
            unique case (state)
                Collect: begin
                    if (AER_OUT_REQ) begin
                        if (is_marker) begin
                            // Marker ACK is withheld until the bitmap is fully drained.
                            word_cnt   <= '0;
                            dout_valid <= 1'b1;
                            state      <= Drain;
                        end else begin
                            if (spike_ok) begin
                                bitmap[AER_OUT_ADDR[9:0]] <= 1'b1;
                            end else begin
                                addr_err <= 1'b1;
                            end
                            AER_OUT_ACK <= 1'b1;
                            state       <= HoldAck;
                        end
                    end
                end
                HoldAck: begin
                    if (!AER_OUT_REQ) begin
                        AER_OUT_ACK <= 1'b0;
                        state       <= Collect;
                    end
                end
                Drain: begin
                    if (dout_ready) begin
                        if (last_word) begin
                            bitmap      <= '0;
                            word_cnt    <= '0;
                            tstep_cnt   <= (tstep_cnt == LAST_STEP) ? 4'd0 : tstep_cnt + 4'd1;
                            finish      <= tstep_cnt == LAST_STEP;
                            dout_valid  <= 1'b0;
                            AER_OUT_ACK <= 1'b1;
                            state       <= HoldAck;
                        end else begin
                            word_cnt <= word_cnt + WCW'(1);
                        end
                    end
                end
                default: state <= Collect;
            endcase
        end
    end

endmodule

// File: tb/tb_aer_to_parallel.sv
// Directed bench for aer_to_parallel: spike/marker handshakes, bitmap drain under
// back-pressure, timestep wrap with finish, address errors and asynchronous reset.
module tb_aer_to_parallel;

    localparam int WORDS = 196;

    logic        CLK = 1'b0;
    logic        rst_n = 1'b0;
    logic        AER_OUT_REQ = 1'b0;
    logic [11:0] AER_OUT_ADDR = '0;
    logic        AER_OUT_ACK;
    logic [3:0]  dout_parallel;
    logic        dout_valid;
    logic        dout_ready = 1'b0;
    logic        dout_last;
    logic [3:0]  tstep_cnt;
    logic        finish;
    logic        addr_err;

    int tests = 0;
    int fails = 0;

    logic [783:0] exp_bm;
    logic [3:0]   exp_tstep;
    logic         exp_err;
    logic [3:0]   got [WORDS];
    logic         gl  [WORDS];

    aer_to_parallel #(.DATA_WIDTH(4), .NEURON_NUM(784), .T_STEPS(16)) dut (
        .CLK(CLK), .rst_n(rst_n), .AER_OUT_REQ(AER_OUT_REQ), .AER_OUT_ADDR(AER_OUT_ADDR),
        .AER_OUT_ACK(AER_OUT_ACK), .dout_parallel(dout_parallel), .dout_valid(dout_valid),
        .dout_ready(dout_ready), .dout_last(dout_last), .tstep_cnt(tstep_cnt),
        .finish(finish), .addr_err(addr_err)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] model_word(input int w);
        logic [3:0] r;
        for (int j = 0; j < 4; j++) r[3-j] = exp_bm[w*4+j];
        return r;
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Asserts reset away from a clock edge and checks outputs drop immediately.
    task automatic do_reset(input string tag);
        #2;
        rst_n = 1'b0;
        AER_OUT_REQ = 1'b0;
        dout_ready = 1'b0;
        #1;
        check({tag, "_ack"}, 32'(AER_OUT_ACK), 0);
        check({tag, "_valid"}, 32'(dout_valid), 0);
        check({tag, "_last"}, 32'(dout_last), 0);
        check({tag, "_finish"}, 32'(finish), 0);
        check({tag, "_tstep"}, 32'(tstep_cnt), 0);
        check({tag, "_err"}, 32'(addr_err), 0);
        tick();
        tick();
        rst_n = 1'b1;
        exp_bm = '0;
        exp_tstep = '0;
        exp_err = 1'b0;
        tick();
    endtask

    task automatic send(input logic [11:0] a);
        int n;
        AER_OUT_ADDR = a;
        AER_OUT_REQ = 1'b1;
        n = 0;
        do begin tick(); n++; end while (!AER_OUT_ACK && n < 20);
        check("ack_rise_latency", 32'(n), 1);
        check("ack_rise", 32'(AER_OUT_ACK), 1);
        AER_OUT_REQ = 1'b0;
        n = 0;
        do begin tick(); n++; end while (AER_OUT_ACK && n < 20);
        check("ack_fall", 32'(AER_OUT_ACK), 0);
        if (a[11:10] == 2'b00 && a[9:0] < 10'd784) exp_bm[a[9:0]] = 1'b1;
        else exp_err = 1'b1;
    endtask

    // mode 0: ready always high; mode 1: ready toggles. abort_at >= 0 returns mid-drain.
    task automatic drain(input int mode, input int abort_at);
        int acc = 0;
        int cyc = 0;
        int ack_bad = 0;
        int fin_bad = 0;
        int n;
        logic rdy;
        logic held_v = 1'b0;
        logic [3:0] held_w = '0;
        logic held_l = 1'b0;
        logic exp_fin;
        AER_OUT_ADDR = 12'h400;
        AER_OUT_REQ = 1'b1;
        while (acc < WORDS && cyc < 3000) begin
            if (abort_at >= 0 && acc == abort_at) return;
            rdy = (mode == 0) ? 1'b1 : (cyc % 2 == 0);
            dout_ready = rdy;
            if (dout_valid) begin
                if (AER_OUT_ACK) ack_bad++;
                if (held_v) begin
                    check("stall_word", 32'(dout_parallel), 32'(held_w));
                    check("stall_last", 32'(dout_last), 32'(held_l));
                end
                if (rdy) begin
                    got[acc] = dout_parallel;
                    gl[acc] = dout_last;
                    acc++;
                    held_v = 1'b0;
                end else begin
                    held_w = dout_parallel;
                    held_l = dout_last;
                    held_v = 1'b1;
                end
            end
            if (finish) fin_bad++;
            tick();
            cyc++;
        end
        dout_ready = 1'b0;
        exp_fin = exp_tstep == 4'd15;
        exp_tstep = (exp_tstep == 4'd15) ? 4'd0 : exp_tstep + 4'd1;
        check("drain_count", 32'(acc), WORDS);
        check("drain_ack_low", 32'(ack_bad), 0);
        check("drain_no_finish", 32'(fin_bad), 0);
        check("marker_ack", 32'(AER_OUT_ACK), 1);
        check("finish_pulse", 32'(finish), 32'(exp_fin));
        check("tstep_after", 32'(tstep_cnt), 32'(exp_tstep));
        check("valid_after", 32'(dout_valid), 0);
        for (int w = 0; w < WORDS; w++) begin
            check($sformatf("word%0d", w), 32'(got[w]), 32'(model_word(w)));
            check($sformatf("last%0d", w), 32'(gl[w]), 32'(w == WORDS - 1));
        end
        AER_OUT_REQ = 1'b0;
        n = 0;
        do begin tick(); n++; end while (AER_OUT_ACK && n < 20);
        check("marker_ack_fall", 32'(AER_OUT_ACK), 0);
        check("finish_one_cycle", 32'(finish), 0);
        exp_bm = '0;
    endtask

    initial begin
        exp_bm = '0;
        exp_tstep = '0;
        exp_err = 1'b0;

        // 1: reset values
        do_reset("reset");

        // 2: spikes 0, 5, 783 then full-rate drain
        send(12'd0);
        send(12'd5);
        send(12'd783);
        check("err_clear", 32'(addr_err), 0);
        drain(0, -1);
        check("t2_word0", 32'(got[0]), 32'(4'b1000));
        check("t2_word1", 32'(got[1]), 32'(4'b0100));
        check("t2_word195", 32'(got[195]), 32'(4'b0001));
        check("t2_word100", 32'(got[100]), 32'(4'b0000));

        // 3: back-pressured drain, then the next timestep must be empty
        send(12'd1);
        send(12'd400);
        send(12'd782);
        send(12'd400);
        drain(1, -1);
        check("t3_word0", 32'(got[0]), 32'(4'b0100));
        check("t3_word100", 32'(got[100]), 32'(4'b1000));
        check("t3_word195", 32'(got[195]), 32'(4'b0010));
        drain(0, -1);
        check("t3_empty_word0", 32'(got[0]), 0);

        // 4: sixteen timesteps with a spike on neuron 3; finish on the 16th only
        do_reset("reset4");
        for (int t = 0; t < 16; t++) begin
            check("t4_tstep_before", 32'(tstep_cnt), 32'(t));
            send(12'd3);
            drain(0, -1);
            check("t4_word0", 32'(got[0]), 32'(4'b0001));
        end
        check("t4_wrap", 32'(tstep_cnt), 0);

        // 5: out-of-range and addr[11] spikes set sticky error, bitmap untouched
        send(12'h3FF);
        check("t5_err_a", 32'(addr_err), 1);
        send(12'h800);
        check("t5_err_b", 32'(addr_err), 1);
        drain(0, -1);
        check("t5_err_sticky", 32'(addr_err), 1);
        check("t5_word195", 32'(got[195]), 0);

        // 6: reset mid-drain and mid-handshake
        send(12'd10);
        drain(0, 50);
        check("t6_mid_valid", 32'(dout_valid), 1);
        do_reset("reset_drain");
        AER_OUT_ADDR = 12'd20;
        AER_OUT_REQ = 1'b1;
        tick();
        check("t6_hold_ack", 32'(AER_OUT_ACK), 1);
        do_reset("reset_hold");
        check("t6_tstep", 32'(tstep_cnt), 0);
        drain(0, -1);
        check("t6_word2", 32'(got[2]), 0);
        check("t6_word5", 32'(got[5]), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
